// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Holds the FSM state type, default sizing and the one-hot decode helper.
package rr_grant_arbiter_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = 4;
    // Widest one-hot vector the helper can produce; callers cast down to N bits.
    localparam int N_MAX = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_MAX-1:0] onehot_from_idx(input logic [7:0] idx);
        onehot_from_idx      = '0;
        onehot_from_idx[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the arbiter (master) and its requesters/consumer (slave).
// Handshake: a grant transfers on a rising clk edge where gnt_valid && gnt_ready; while
// gnt_valid is high and gnt_ready low, gnt_idx/gnt_onehot hold; gnt_ready is ignored when
// gnt_valid is low.
interface rr_grant_arbiter_if #(
    parameter int N = 16,
    parameter int W = 4
);
    logic [N-1:0] req;
    logic         gnt_valid;
    logic         gnt_ready;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;
    logic         req_none;
    logic [W-1:0] ptr;

    modport master (
        input  req, gnt_ready,
        output gnt_valid, gnt_idx, gnt_onehot, req_none, ptr
    );

    modport slave (
        output req, gnt_ready,
        input  gnt_valid, gnt_idx, gnt_onehot, req_none, ptr
    );
endinterface

// File: rtl/rr_grant_arbiter_prio_enc.sv
// Combinational rotating-priority encoder: first set bit of req searching
// upward from start, wrapping modulo N.
module rr_prio_enc
    import rr_grant_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] cand;
    logic         hit;

    // W-bit addition gives the modulo-N wrap for free since N is 2**W.
    always_comb begin
        idx_o = start_i;
        cand  = '0;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = start_i + W'(i);
            if (!hit && req_i[cand]) begin
                hit   = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with registered valid/ready grant output and fair pointer.
// Optional watchdog (gnt_timeout, TIMEOUT) compiled in with RR_ARB_WATCHDOG_EN.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
`ifdef RR_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef RR_ARB_WATCHDOG_EN
    output logic                 gnt_timeout,
`endif
    rr_grant_arbiter_if.master   bus,
    output state_t               state_o
);

    state_t       state_q, state_d;
    logic [W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         req_none_q;

    logic         accept;
    logic [W-1:0] p_eff;
    logic [W-1:0] win_idx;
    logic         found;
    logic [N-1:0] win_onehot;

    assign accept     = (state_q == GRANT) && bus.gnt_ready;
    // On accept the search restarts just past the winner, so it has lowest priority.
    assign p_eff      = accept ? (gnt_idx_q + W'(1)) : ptr_q;
    assign win_onehot = N'(onehot_from_idx(8'(win_idx)));

    rr_prio_enc #(.N(N), .W(W)) u_enc (
        .req_i   (bus.req),
        .start_i (p_eff),
        .idx_o   (win_idx),
        .found_o (found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        onehot_d  = onehot_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = GRANT;
                    gnt_idx_d = win_idx;
                    onehot_d  = win_onehot;
                end
            end
            GRANT: begin
                if (accept) begin
                    ptr_d = p_eff;
                    if (found) begin
                        gnt_idx_d = win_idx;
                        onehot_d  = win_onehot;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            onehot_q   <= '0;
            ptr_q      <= '0;
            req_none_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            onehot_q   <= onehot_d;
            ptr_q      <= ptr_d;
            req_none_q <= (bus.req == '0);
        end
    end

    assign bus.gnt_valid  = (state_q == GRANT);
    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_onehot = onehot_q;
    assign bus.req_none   = req_none_q;
    assign bus.ptr        = ptr_q;
    assign state_o        = state_q;

`ifdef RR_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_q, wd_d;
    logic          to_q, to_d;

    // Counter saturates at TIMEOUT; the flag is sticky until reset.
    always_comb begin
        wd_d = wd_q;
        to_d = to_q;
        if ((state_q == GRANT) && !accept) begin
            if (wd_q != CW'(TIMEOUT)) wd_d = wd_q + CW'(1);
        end else begin
            wd_d = '0;
        end
        if (wd_d == CW'(TIMEOUT)) to_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign gnt_timeout = to_q;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter against a queue-free behavioural model.
// Watchdog checks are included when RR_ARB_WATCHDOG_EN is defined (TIMEOUT=4).
module tb_rr_grant_arbiter;
  import rr_grant_arbiter_pkg::*;

  localparam int N = 16;
  localparam int W = 4;
`ifdef RR_ARB_WATCHDOG_EN
  localparam int TO = 4;
`endif

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
`ifdef RR_ARB_WATCHDOG_EN
  logic   gnt_timeout;
`endif

  rr_grant_arbiter_if #(.N(N), .W(W)) bus ();

  rr_grant_arbiter #(
    .N(N), .W(W)
`ifdef RR_ARB_WATCHDOG_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef RR_ARB_WATCHDOG_EN
    .gnt_timeout (gnt_timeout),
`endif
    .bus         (bus),
    .state_o     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  bit m_req_none;
  int m_cnt;
  bit m_to;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return start;
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [N-1:0] oh;
    oh = '0;
    if (m_valid) oh[m_idx] = 1'b1;
    return {m_valid, m_valid, m_valid ? 4'(m_idx) : 4'd0, 4'(m_ptr), oh, m_req_none};
  endfunction

  function automatic logic [26:0] obs_vec();
    return {dbg_state == GRANT, bus.gnt_valid, bus.gnt_valid ? bus.gnt_idx : 4'd0,
            bus.ptr, bus.gnt_onehot, bus.req_none};
  endfunction

  // driver: apply inputs, advance one edge, advance model, settle
  task automatic step(input logic [N-1:0] r, input logic rdy, input logic rst);
    bit acc;
    int start;
    bus.req       = r;
    bus.gnt_ready = rdy;
    rst_n         = rst;
    @(posedge clk);
    if (!rst) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_req_none = 1; m_cnt = 0; m_to = 0;
    end else begin
      acc = m_valid && rdy;
`ifdef RR_ARB_WATCHDOG_EN
      if (m_valid && !acc) m_cnt = (m_cnt + 1 > TO) ? TO : m_cnt + 1;
      else m_cnt = 0;
      if (m_cnt >= TO) m_to = 1;
`endif
      if (!m_valid || acc) begin
        start = acc ? (m_idx + 1) % N : m_ptr;
        if (acc) m_ptr = start;
        if (r != '0) begin
          m_valid = 1;
          m_idx   = pick(r, start);
        end else begin
          m_valid = 0;
        end
      end
      m_req_none = (r == '0);
    end
    #1;
  endtask

  task automatic test_reset();
    step(16'hFFFF, 1'b0, 1'b0);
    step(16'hFFFF, 1'b0, 1'b0);
    n_checks++;
    if (bus.gnt_valid !== 1'b0 || bus.ptr !== 4'd0 || bus.req_none !== 1'b1 ||
        bus.gnt_onehot !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_vals got v=%b ptr=%0d rn=%b oh=%h exp v=0 ptr=0 rn=1 oh=0",
               bus.gnt_valid, bus.ptr, bus.req_none, bus.gnt_onehot);
    end
    step(16'hFFFF, 1'b0, 1'b1);
    n_checks++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 4'd0 || bus.gnt_onehot !== 16'h0001) begin
      n_errors++;
      $display("FAIL reset_release got v=%b idx=%0d oh=%h exp v=1 idx=0 oh=0001",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
  endtask

  task automatic test_rotation();
    for (int k = 1; k <= 17; k++) begin
      step(16'hFFFF, 1'b1, 1'b1);
      n_checks++;
      if (bus.gnt_idx !== 4'(k % 16) || bus.ptr !== 4'(k % 16) || bus.gnt_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL rotation[%0d] got idx=%0d ptr=%0d v=%b exp idx=%0d ptr=%0d v=1",
                 k, bus.gnt_idx, bus.ptr, bus.gnt_valid, k % 16, k % 16);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL rotation_model[%0d] got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0200, 1'b0, 1'b1);
    step(16'h0021, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_idx !== 4'd0 || bus.ptr !== 4'd10 || bus.gnt_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_first got idx=%0d ptr=%0d v=%b exp idx=0 ptr=10 v=1",
               bus.gnt_idx, bus.ptr, bus.gnt_valid);
    end
    step(16'h0021, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_idx !== 4'd5 || bus.ptr !== 4'd1 || bus.gnt_onehot !== 16'h0020) begin
      n_errors++;
      $display("FAIL wrap_second got idx=%0d ptr=%0d oh=%h exp idx=5 ptr=1 oh=0020",
               bus.gnt_idx, bus.ptr, bus.gnt_onehot);
    end
  endtask

  task automatic test_hold_and_idle();
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(16'h0100, 1'b0, 1'b1);
      n_checks++;
      if (bus.gnt_idx !== 4'd3 || bus.gnt_valid !== 1'b1 || bus.gnt_onehot !== 16'h0008) begin
        n_errors++;
        $display("FAIL hold[%0d] got idx=%0d v=%b oh=%h exp idx=3 v=1 oh=0008",
                 k, bus.gnt_idx, bus.gnt_valid, bus.gnt_onehot);
      end
    end
    step(16'h0100, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_idx !== 4'd8 || bus.gnt_valid !== 1'b1 || bus.ptr !== 4'd4) begin
      n_errors++;
      $display("FAIL back_to_back got idx=%0d v=%b ptr=%0d exp idx=8 v=1 ptr=4",
               bus.gnt_idx, bus.gnt_valid, bus.ptr);
    end
    step(16'h0000, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 16'h0 || bus.req_none !== 1'b1 ||
        dbg_state !== IDLE || bus.ptr !== 4'd9) begin
      n_errors++;
      $display("FAIL to_idle got v=%b oh=%h rn=%b st=%b ptr=%0d exp v=0 oh=0 rn=1 st=0 ptr=9",
               bus.gnt_valid, bus.gnt_onehot, bus.req_none, dbg_state, bus.ptr);
    end
    step(16'h0000, 1'b1, 1'b1);
    n_checks++;
    if (bus.ptr !== 4'd9 || bus.gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_ptr got ptr=%0d v=%b exp ptr=9 v=0", bus.ptr, bus.gnt_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    step(16'h0040, 1'b0, 1'b1);
    step(16'h0040, 1'b1, 1'b0);
    n_checks++;
    if (bus.gnt_valid !== 1'b0 || bus.ptr !== 4'd0 || bus.gnt_onehot !== 16'h0 ||
        bus.req_none !== 1'b1 || bus.gnt_idx !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_mid got v=%b ptr=%0d oh=%h rn=%b idx=%0d exp v=0 ptr=0 oh=0 rn=1 idx=0",
               bus.gnt_valid, bus.ptr, bus.gnt_onehot, bus.req_none, bus.gnt_idx);
    end
  endtask

`ifdef RR_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0004, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(16'h0004, 1'b0, 1'b1);
      n_checks++;
      if (gnt_timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL wd_early[%0d] got=%b exp=0", k, gnt_timeout);
      end
    end
    step(16'h0004, 1'b0, 1'b1);
    n_checks++;
    if (gnt_timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL wd_fire got=%b exp=1", gnt_timeout);
    end
    step(16'h0004, 1'b1, 1'b1);
    step(16'h0000, 1'b1, 1'b1);
    n_checks++;
    if (gnt_timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL wd_sticky got=%b exp=1", gnt_timeout);
    end
  endtask
`endif

  task automatic test_random();
    step(16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      logic rdy, rst;
      case ($urandom_range(0, 3))
        0: r = 16'($urandom);
        1: r = 16'h1 << $urandom_range(0, 15);
        2: r = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: r = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) != 0);
      step(r, rdy, rst);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random[%0d] got=%h exp=%h", k, obs_vec(), exp_vec());
      end
`ifdef RR_ARB_WATCHDOG_EN
      n_checks++;
      if (gnt_timeout !== m_to) begin
        n_errors++;
        $display("FAIL random_wd[%0d] got=%b exp=%b", k, gnt_timeout, m_to);
      end
`endif
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.gnt_ready = 1'b0;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_req_none = 1; m_cnt = 0; m_to = 0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_wrap();
    test_hold_and_idle();
    test_reset_mid_grant();
`ifdef RR_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
